// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        LOAD,
        DONE,
        ERROR
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/inst_mem_loader_byte_assembler.sv
// Shifts accepted bytes into a big-endian word; word_ready_o pulses combinationally
// with the 4th byte, when word_o already contains that byte in its low lane.
module byte_assembler
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    // Only the three older bytes need storage; the newest one comes straight from byte_i.
    logic [23:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (accept_i) begin
            data_d = {data_q[15:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    assign word_o       = {data_q, byte_i};
    assign word_ready_o = accept_i && (cnt_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed byte image into instruction RAM from word 0 upward,
// holding the CPU in reset until the last word is written.
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int G       = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   byte_i,
    input  logic         byte_valid_i,
    output logic         mem_we_o,
    output logic [G-1:0] mem_addr_o,
    output logic [31:0]  mem_data_o,
    output logic         cpu_rst_o,
    output logic         done_o,
    output logic         error_o
);

    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]     CAP    = 32'(1) << G;

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [G:0]    word_cnt_q, word_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mem_we_q, mem_we_d;
    logic [G-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [15:0]   n_full;
    logic          accept;
    logic          load_done;
    logic          word_ready;
    logic [31:0]   word;

    // The counter already advanced with the final pulse, so equality with N marks the last write cycle.
    assign load_done = (state_q == LOAD) && mem_we_q && (32'(word_cnt_q) == 32'(n_q));
    assign accept    = byte_valid_i && (state_q == LOAD) && !load_done;

    byte_assembler u_asm (
        .clk          (CLK),
        .rst          (RST),
        .accept_i     (accept),
        .byte_i       (byte_i),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        error_d    = error_q;
        n_full     = {n_q[15:8], byte_i};

        case (state_q)
            HDR_HI: begin
                timer_d = '0;
                if (byte_valid_i) begin
                    n_d     = {byte_i, 8'h00};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (byte_valid_i) begin
                    timer_d    = '0;
                    n_d        = n_full;
                    word_cnt_d = '0;
                    if (n_full == 16'd0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else if (32'(n_full) > CAP) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (timer_q == T_LAST) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LOAD: begin
                if (load_done) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                    timer_d   = '0;
                end else if (accept) begin
                    timer_d = '0;
                    if (word_ready) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = word_cnt_q[G-1:0];
                        mem_data_d = word;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else if (timer_q == T_LAST) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE, ERROR: begin
                timer_d = '0;
            end
            default: begin
                state_d = HDR_HI;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= HDR_HI;
            n_q        <= '0;
            word_cnt_q <= '0;
            timer_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed and randomized checks of inst_mem_loader (G=10, TIMEOUT=16); write pulses
// are captured by a monitor and compared with the words the bench itself framed.
module tb_inst_mem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        error_o;

    int tests = 0;
    int fails = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];

    inst_mem_loader #(.G(10), .TIMEOUT(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mem_we_o === 1'b1) begin
            wa_q.push_back(mem_addr_o);
            wd_q.push_back(mem_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        byte_valid_i = 1'b1;
        byte_i       = b;
        tick();
        byte_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        logic [31:0] words[$];
        logic [15:0] nn;
        logic [7:0]  b;
        int          n, cut, nwr;

        // Reset values
        RST = 1'b1;
        tick();
        tick();
        check("rst_we",      32'(mem_we_o),   32'd0);
        check("rst_addr",    32'(mem_addr_o), 32'd0);
        check("rst_data",    mem_data_o,      32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_o),  32'd1);
        check("rst_done",    32'(done_o),     32'd0);
        check("rst_error",   32'(error_o),    32'd0);

        // Two words, one byte every third cycle
        reset_dut();
        send(8'h00, 2); send(8'h02, 2);
        send(8'hDE, 2); send(8'hAD, 2); send(8'hBE, 2); send(8'hEF, 0);
        check("t1_we0",   32'(mem_we_o),   32'd1);
        check("t1_addr0", 32'(mem_addr_o), 32'd0);
        check("t1_data0", mem_data_o,      32'hDEADBEEF);
        tick();
        check("t1_we0_single", 32'(mem_we_o), 32'd0);
        tick();
        send(8'h00, 2); send(8'h00, 2); send(8'h00, 2); send(8'h2A, 0);
        check("t1_we1",      32'(mem_we_o),   32'd1);
        check("t1_addr1",    32'(mem_addr_o), 32'd1);
        check("t1_data1",    mem_data_o,      32'h0000002A);
        check("t1_done_pre", 32'(done_o),     32'd0);
        check("t1_rst_pre",  32'(cpu_rst_o),  32'd1);
        tick();
        check("t1_done",   32'(done_o),     32'd1);
        check("t1_cpurst", 32'(cpu_rst_o),  32'd0);
        check("t1_we_off", 32'(mem_we_o),   32'd0);
        check("t1_addr_hold", 32'(mem_addr_o), 32'd1);
        check("t1_nwr",    32'(wa_q.size()), 32'd2);

        // Empty image
        reset_dut();
        send(8'h00, 2); send(8'h00, 0);
        check("t2_done",   32'(done_o),    32'd1);
        check("t2_cpurst", 32'(cpu_rst_o), 32'd0);
        repeat (4) tick();
        check("t2_nwr", 32'(wa_q.size()), 32'd0);

        // Back-to-back bytes
        reset_dut();
        send(8'h00, 0); send(8'h01, 0); send(8'h11, 0);
        send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check("t3_we",   32'(mem_we_o),   32'd1);
        check("t3_addr", 32'(mem_addr_o), 32'd0);
        check("t3_data", mem_data_o,      32'h11223344);
        tick();
        check("t3_done", 32'(done_o), 32'd1);
        check("t3_nwr",  32'(wa_q.size()), 32'd1);

        // Oversized image (N = 1025 > 2^10)
        reset_dut();
        send(8'h04, 1); send(8'h01, 0);
        check("t4_error",  32'(error_o),   32'd1);
        check("t4_cpurst", 32'(cpu_rst_o), 32'd1);
        send(8'h00, 1); send(8'h00, 1); send(8'h00, 1); send(8'h01, 1);
        send(8'h12, 1); send(8'h34, 1); send(8'h56, 1); send(8'h78, 3);
        check("t4_nwr",        32'(wa_q.size()), 32'd0);
        check("t4_error_hold", 32'(error_o),     32'd1);
        check("t4_done",       32'(done_o),      32'd0);

        // Timeout in the middle of a word
        reset_dut();
        send(8'h00, 1); send(8'h01, 1); send(8'hAA, 1); send(8'hBB, 0);
        repeat (15) tick();
        check("t5_error_early", 32'(error_o), 32'd0);
        tick();
        check("t5_error",  32'(error_o),     32'd1);
        check("t5_cpurst", 32'(cpu_rst_o),   32'd1);
        check("t5_nwr",    32'(wa_q.size()), 32'd0);

        // Reset mid-load, then a fresh load overwrites from address 0
        reset_dut();
        send(8'h00, 1); send(8'h03, 1);
        send(8'hCA, 1); send(8'hFE, 1); send(8'hBA, 1); send(8'hBE, 1);
        send(8'h11, 1); send(8'h22, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_cpurst_rst", 32'(cpu_rst_o), 32'd1);
        check("t6_done_rst",   32'(done_o),    32'd0);
        send(8'h00, 1); send(8'h01, 1);
        send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 0);
        check("t6_data", mem_data_o,      32'h01020304);
        check("t6_addr", 32'(mem_addr_o), 32'd0);
        tick();
        check("t6_done", 32'(done_o), 32'd1);
        check("t6_nwr",  32'(wa_q.size()), 32'd2);
        if (wd_q.size() == 2) begin
            check("t6_first_word", wd_q[0], 32'hCAFEBABE);
            check("t6_first_addr", 32'(wa_q[0]), 32'd0);
        end

        // Randomized images with random gaps; every third one is cut short by silence
        for (int it = 0; it < 24; it++) begin
            reset_dut();
            words.delete();
            n   = int'($urandom_range(1, 8));
            cut = (it % 3 == 2) ? int'($urandom_range(0, 4 * n - 2)) : -1;
            for (int w = 0; w < n; w++) words.push_back($urandom);
            nn = 16'(n);
            send(nn[15:8], int'($urandom_range(0, 5)));
            send(nn[7:0],  int'($urandom_range(0, 5)));
            for (int p = 0; p < 4 * n; p++) begin
                b = 8'(words[p / 4] >> (8 * (3 - (p % 4))));
                if (p == cut) begin
                    send(b, 20);
                    break;
                end
                send(b, int'($urandom_range(0, 5)));
            end
            repeat (20) tick();
            nwr = (cut >= 0) ? (cut + 1) / 4 : n;
            check("rnd_nwr",    32'(wa_q.size()), 32'(nwr));
            for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
                check("rnd_addr", 32'(wa_q[i]), 32'(i));
                check("rnd_data", wd_q[i],      words[i]);
            end
            check("rnd_done",   32'(done_o),    (cut < 0) ? 32'd1 : 32'd0);
            check("rnd_error",  32'(error_o),   (cut < 0) ? 32'd0 : 32'd1);
            check("rnd_cpurst", 32'(cpu_rst_o), (cut < 0) ? 32'd0 : 32'd1);
            if (cut < 0) begin
                for (int k = 0; k < 4; k++) send(8'($urandom), 0);
                repeat (3) tick();
                check("rnd_ignore_nwr", 32'(wa_q.size()), 32'(n));
                check("rnd_addr_hold",  32'(mem_addr_o),  32'(n - 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction memory: fills the instruction RAM that the fetch stage later reads with word addresses taken from the PC, where the PC increments by 1 per instruction.
- Receives a byte stream (e.g. from a UART receiver) and assembles big-endian 32-bit instruction words.
- Writes those words to consecutive word addresses starting at 0.
- Holds the CPU pipeline (PC register and pipe registers) in reset until the image is fully loaded.

Parameters:
G, 10, instruction memory word-address width; capacity is 2^G words.
TIMEOUT, 1000000, maximum idle cycles allowed between bytes once a load has started.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
byte_i  input  8  received byte.
byte_valid_i  input  1  one-cycle strobe qualifying byte_i.
mem_we_o  output  1  instruction memory write enable, one-cycle pulse.
mem_addr_o  output  G  instruction memory word address.
mem_data_o  output  32  instruction word to write.
cpu_rst_o  output  1  reset for the PC, pipe registers and data memory; high while loading.
done_o  output  1  high once the image has loaded successfully.
error_o  output  1  high after a timeout or a size overflow.

Behaviour:
- Clocking and reset:
  - One clock, CLK. RST is synchronous and active-high.
  - Reset values: mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_rst_o=1, done_o=0, error_o=0. State=HDR_HI, byte counter=0, word counter=0, timer=0.
- Frame format:
  - Header: 16-bit word count N, high byte first.
  - Payload: N words, 4 bytes each, most significant byte first.
- States:
  - HDR_HI: wait indefinitely. On byte_valid_i, latch N[15:8] and go to HDR_LO.
  - HDR_LO: on byte_valid_i, latch N[7:0] and evaluate N:
    - N=0: go to DONE.
    - N>2^G: go to ERROR.
    - otherwise: go to LOAD.
  - LOAD:
    - Each accepted byte shifts into a 32-bit assembly register: data = {data[23:0], byte_i}.
    - The 2-bit byte counter advances on each accepted byte.
    - When the 4th byte of a word is accepted: the next cycle drives mem_we_o=1 for exactly one cycle, with mem_data_o = the assembled word and mem_addr_o = the word counter.
    - After that write cycle the word counter increments.
    - A byte_valid_i arriving in the write-pulse cycle is accepted as byte 0 of the next word. No byte is ever dropped.
    - After the write of word N-1, go to DONE.
  - DONE: cpu_rst_o=0 and done_o=1, starting the cycle after the final mem_we_o pulse. All further bytes are ignored. Only RST leaves DONE.
  - ERROR: error_o=1, cpu_rst_o stays 1, mem_we_o=0. Bytes are ignored. Only RST leaves ERROR.
- Timeout:
  - The timer counts cycles without byte_valid_i while in HDR_LO or LOAD.
  - It clears to 0 on every accepted byte.
  - When it reaches TIMEOUT-1 without a byte, go to ERROR the following cycle. A partially assembled word is not written.
- Address behaviour:
  - mem_addr_o holds its last value between writes.
  - The word counter is G+1 bits internally. The write for word index 2^G never occurs, because the overflow check rejects N>2^G.
- Simultaneous and mid-operation events:
  - RST asserted at any time takes priority over everything else.
  - Mid-load, RST returns the block to HDR_HI with cpu_rst_o=1. Memory contents already written are left as they are, and the next load overwrites them from address 0.
  - byte_valid_i in the same cycle the timer expires: the byte wins and the timer clears.

Decomposition:
- Package inst_loader_pkg holds:
  - state enum {HDR_HI, HDR_LO, LOAD, DONE, ERROR};
  - WORD_BYTES=4;
  - HDR_BYTES=2.
- Sub-module byte_assembler handles byte shift-in and the 2-bit byte count. Its output word_ready pulses when the 4th byte is accepted.
- The top level holds the FSM, the word/address counter, the timer and the output registers.

Test Plan:
- Reset, then bytes 00 02 | DE AD BE EF | 00 00 00 2A, one per 3 cycles -> two writes: mem_we_o pulses (addr 0, 0xDEADBEEF) and (addr 1, 0x0000002A). cpu_rst_o falls and done_o rises the cycle after the second pulse.
- Bytes 00 00 -> no mem_we_o pulse; done_o=1 and cpu_rst_o=0 the cycle after the second header byte.
- Back-to-back bytes 00 01 11 22 33 44 with byte_valid_i held high continuously -> one write at addr 0 with data 0x11223344, and no byte lost.
- With G=10, header 04 01 (N=1025) -> error_o=1, cpu_rst_o=1, no writes; subsequent bytes are ignored.
- With TIMEOUT=16, header 00 01 followed by bytes AA BB then silence -> error_o=1 sixteen cycles after BB, and no write occurs.
- Header 00 03, one full word written, RST pulsed mid-word, then header 00 01 with 01 02 03 04 -> write at addr 0 with 0x01020304, then done_o=1.
